mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer for the single main-memory port shared by the instruction-cache refill path (fetch stage) and the data-cache refill/writeback path (memory stage). It grants one requester at a time and drives the fixed-latency memory interface for the whole access. It returns the line, or a write completion, with a one-cycle ready pulse. Pipeline stalls elsewhere are derived from the requester holding `req` while `ready` is low.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `LINE_W`, 128, cache line width in bits
- `MEM_LAT`, 10, memory access latency in cycles (≥1)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- `ic_req`  in  1  instruction-side line read request, held until `ic_ready`
- `ic_addr`  in  ADDR_W  instruction line address, stable while `ic_req`
- `ic_ready`  out  1  one-cycle pulse: `ic_rdata` valid
- `ic_rdata`  out  LINE_W  returned instruction line
- `dc_req`  in  1  data-side request, held until `dc_ready`
- `dc_we`  in  1  1 = line writeback, 0 = line read
- `dc_addr`  in  ADDR_W  data line address
- `dc_wdata`  in  LINE_W  writeback line
- `dc_ready`  out  1  one-cycle pulse: access complete; `dc_rdata` valid on reads
- `dc_rdata`  out  LINE_W  returned data line
- `mem_en`  out  1  memory access active
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  LINE_W  memory write data
- `mem_rdata`  in  LINE_W  memory read data, valid in the last cycle of an access
- `busy`  out  1  arbiter not in IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: when neither request is active, stay in IDLE.
- IDLE, request present:
  - Choose a grant (rules below).
  - Latch the granted requester's address, `we` and wdata into registers. The instruction side always uses `we`=0.
  - Load counter with MEM_LAT-1 and go to BUSY.
- Grant rules:
  - Only one request active: grant it.
  - Both active: grant the side not in `last_grant` (alternation).
  - `last_grant` updates on every grant. Its reset value is IC, so the data side wins the first tie.
- BUSY:
  - `mem_en`=1, and `mem_we`/`mem_addr`/`mem_wdata` are driven from the latched registers.
  - Counter decrements each cycle.
  - When counter==0: on reads, capture `mem_rdata` into the granted side's rdata register; then go to DONE.
- DONE:
  - Pulse `ic_ready` or `dc_ready` (granted side only) for exactly one cycle, then return to IDLE.
  - Requests are ignored in DONE.
- Requester rule: deassert `req`, or present a new request, in the cycle after `ready`.
- rdata registers hold their value until the next read capture for that side. A writeback leaves `dc_rdata` unchanged.
- A request arriving while BUSY/DONE for the other side waits; it is considered in the next IDLE cycle.
- Counter width is clog2(MEM_LAT)+1. No wrap: it only counts down from MEM_LAT-1 to 0.

## Timing
- Reset (0): state=IDLE, `last_grant`=IC, counter=0, latched address/data=0, `ic_rdata`=`dc_rdata`=0. All outputs 0: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `ic_ready`, `dc_ready`, `busy`.
- Reset mid-access: the access is abandoned, no ready is issued, and a pending requester must reissue.
- Request sampled in IDLE at edge E0.
  - BUSY for the cycles following edges E0 through E(MEM_LAT-1): `mem_en` high for exactly MEM_LAT cycles.
  - `mem_rdata` is sampled at edge E(MEM_LAT).
  - DONE in the following cycle, with `ready` high exactly one cycle.
- Request-to-ready latency is MEM_LAT+1 edges. The next grant occurs at earliest 1 cycle after DONE (IDLE sampling).
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- `busy`=1 in BUSY and DONE.
- Outputs are registered (Moore); no combinational path from `req` to `ready` or the `mem_*` outputs.

## Test plan
- Reset check: with `reset`=0 and all requests high, every output stays 0. Release reset with `ic_req`=1, `ic_addr`=0x100, MEM_LAT=10, memory returning 0xAAAA…: `mem_en` is high for 10 cycles with `mem_addr`=0x100, `ic_ready` pulses 11 cycles after the sampling edge, and `ic_rdata`=0xAAAA….
- Data writeback: `dc_req`=1, `dc_we`=1, `dc_addr`=0x2000, `dc_wdata`=0x1234… → `mem_we`=1 for 10 cycles with that address/data, then one `dc_ready` pulse; `dc_rdata` is unchanged from its prior value.
- Tie and alternation: `ic_req` and `dc_req` both held continuously and re-raised after each ready → grant order D, I, D, I, and `busy` drops for exactly one cycle between accesses.
- Late contender: `ic_req` raised 3 cycles into a data access → `ic_ready` arrives 1 (DONE) + 1 (IDLE) + 11 cycles after the `dc_ready`-producing access ends. There is no `mem_en` overlap, and `mem_addr` switches only at the grant.
- Reset mid-access: `reset` pulsed low at BUSY cycle 5 → state returns to IDLE at once and no ready pulse occurs. A re-requested read then completes normally with full latency.
- MEM_LAT=1 build: a single read gives `mem_en` high for 1 cycle and `ready` 2 edges after sampling.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared main-memory port: I-cache refill vs D-cache refill/writeback.
// One access at a time, fixed latency, one-cycle ready pulse back to the granted side.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned MEM_LAT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;
  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LINE_W-1:0]  ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0]  dc_rdata_q, dc_rdata_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic               ic_ready_q, ic_ready_d;
  logic               dc_ready_q, dc_ready_d;
  logic               busy_q, busy_d;
  logic               gnt_sel;

  // Next-state: grant/latch in IDLE, count down in BUSY, one DONE cycle for the ready pulse
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    gnt_sel    = GNT_IC;

    case (state_q)
      S_IDLE: begin
        if (ic_req || dc_req) begin
          // On a tie, the side that did not get the previous grant wins
          gnt_sel = (ic_req && dc_req) ? ~last_q : dc_req;
          gnt_d   = gnt_sel;
          last_d  = gnt_sel;
          addr_d  = (gnt_sel == GNT_DC) ? dc_addr : ic_addr;
          we_d    = (gnt_sel == GNT_DC) && dc_we;
          wdata_d = (gnt_sel == GNT_DC) ? dc_wdata : '0;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (gnt_q == GNT_DC) dc_rdata_d = mem_rdata;
            else                 ic_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Moore outputs decoded from the next state so they leave straight from flops
    mem_en_d   = (state_d == S_BUSY);
    mem_we_d   = (state_d == S_BUSY) && we_d;
    busy_d     = (state_d != S_IDLE);
    ic_ready_d = (state_d == S_DONE) && (gnt_d == GNT_IC);
    dc_ready_d = (state_d == S_DONE) && (gnt_d == GNT_DC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= GNT_IC;
      gnt_q      <= GNT_IC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      ic_ready_q <= ic_ready_d;
      dc_ready_q <= dc_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign ic_ready  = ic_ready_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_ready  = dc_ready_q;
  assign dc_rdata  = dc_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timestamp-based access model checked every cycle, plus directed
// scenarios with literal expectations (reset, read, writeback, tie, late contender, MEM_LAT=1).
module tb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 128;
  localparam int unsigned LAT = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0, mem_rdata = '0;
  logic          ic_ready, dc_ready, mem_en, mem_we, busy;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          ic_req1 = 1'b0, dc_req1 = 1'b0;
  logic          ic_ready1, dc_ready1, mem_en1, mem_we1, busy1;
  logic [LW-1:0] ic_rdata1, dc_rdata1, mem_wdata1;
  logic [AW-1:0] mem_addr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .ic_req(ic_req1), .ic_addr(ic_addr), .ic_ready(ic_ready1), .ic_rdata(ic_rdata1),
    .dc_req(dc_req1), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready1), .dc_rdata(dc_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata), .busy(busy1)
  );

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access is (grant edge, side, latched request); outputs follow from its age
  int            edge_n = 0;
  logic          m_active = 1'b0;
  int            m_start = 0;
  logic          m_gnt = 1'b0, m_last = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0, m_ic_rd = '0, m_dc_rd = '0;

  function automatic void m_clear();
    m_active = 1'b0;
    m_last   = 1'b0;
    m_gnt    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_ic_rd  = '0;
    m_dc_rd  = '0;
  endfunction

  always @(negedge reset) m_clear();

  always @(posedge clk) begin
    edge_n++;
    if (!reset) begin
      m_clear();
    end else if (!m_active) begin
      if (ic_req || dc_req) begin
        m_gnt    = (ic_req && dc_req) ? !m_last : dc_req;
        m_last   = m_gnt;
        m_active = 1'b1;
        m_start  = edge_n;
        m_addr   = m_gnt ? dc_addr : ic_addr;
        m_we     = m_gnt && dc_we;
        m_wdata  = m_gnt ? dc_wdata : '0;
      end
    end else if (edge_n - m_start == int'(LAT)) begin
      if (!m_we) begin
        if (m_gnt) m_dc_rd = mem_rdata;
        else       m_ic_rd = mem_rdata;
      end
    end else if (edge_n - m_start == int'(LAT) + 1) begin
      m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    int   age;
    logic e_en, e_rdy;
    age   = edge_n - m_start;
    e_en  = m_active && (age < int'(LAT));
    e_rdy = m_active && (age == int'(LAT));
    chk_b("mem_en",   mem_en,   e_en);
    chk_b("mem_we",   mem_we,   e_en && m_we);
    chk_v("mem_addr", LW'(mem_addr), LW'(m_addr));
    chk_v("mem_wdata", mem_wdata, m_wdata);
    chk_b("busy",     busy,     m_active);
    chk_b("ic_ready", ic_ready, e_rdy && !m_gnt);
    chk_b("dc_ready", dc_ready, e_rdy && m_gnt);
    chk_v("ic_rdata", ic_rdata, m_ic_rd);
    chk_v("dc_rdata", dc_rdata, m_dc_rd);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Advance until the main DUT pulses a ready; steps counts edges from the first step taken
  task automatic run_until_ready(output int side, output int steps, output int en_cnt,
                                 output int we_cnt);
    side = -1; steps = 0; en_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 40 && side < 0; i++) begin
      step();
      steps++;
      if (mem_en) en_cnt++;
      if (mem_we) we_cnt++;
      if (ic_ready)      side = 0;
      else if (dc_ready) side = 1;
    end
    checks++;
    if (side < 0) begin
      errors++;
      $display("FAIL ready_timeout: no ready within 40 cycles at %0t", $time);
    end
  endtask

  initial begin
    int side, steps, en, we;
    logic [LW-1:0] line;

    // Reset held with every request high
    ic_req = 1'b1; dc_req = 1'b1; ic_req1 = 1'b1; dc_req1 = 1'b1;
    repeat (3) begin
      step();
      chk_b("rst_mem_en", mem_en, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_ready", ic_ready | dc_ready, 1'b0);
      chk_b("rst_busy1", busy1, 1'b0);
    end

    // Instruction read right out of reset
    dc_req = 1'b0; ic_req1 = 1'b0; dc_req1 = 1'b0;
    ic_addr = 32'h100; mem_rdata = {8{16'hAAAA}};
    reset = 1'b1;
    run_until_ready(side, steps, en, we);
    chk_i("t1_side", side, 0);
    chk_i("t1_steps", steps, 11);
    chk_i("t1_en_cycles", en, 10);
    chk_v("t1_ic_rdata", ic_rdata, {8{16'hAAAA}});
    chk_v("t1_mem_addr", LW'(mem_addr), LW'(32'h100));
    ic_req = 1'b0;
    step();
    chk_b("t1_idle_busy", busy, 1'b0);

    // Data read, then writeback that must leave dc_rdata alone
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h3000; mem_rdata = {8{16'h5555}};
    run_until_ready(side, steps, en, we);
    chk_i("t2a_side", side, 1);
    chk_i("t2a_steps", steps, 11);
    chk_v("t2a_dc_rdata", dc_rdata, {8{16'h5555}});
    dc_req = 1'b0;
    step();
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h2000; dc_wdata = {4{32'h12345678}};
    mem_rdata = {8{16'hFFFF}};
    run_until_ready(side, steps, en, we);
    chk_i("t2b_side", side, 1);
    chk_i("t2b_we_cycles", we, 10);
    chk_v("t2b_mem_wdata", mem_wdata, {4{32'h12345678}});
    chk_v("t2b_dc_rdata_kept", dc_rdata, {8{16'h5555}});
    dc_req = 1'b0; dc_we = 1'b0;
    step();

    // Tie with both held: D, I, D, I after a fresh reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    ic_addr = 32'h700; dc_addr = 32'h800; ic_req = 1'b1; dc_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      line = {4{32'hC0DE0000 + 32'(k)}};
      mem_rdata = line;
      run_until_ready(side, steps, en, we);
      chk_i("t3_order", side, (k % 2 == 0) ? 1 : 0);
      chk_i("t3_steps", steps, 11);
      chk_v("t3_rdata", (side == 1) ? dc_rdata : ic_rdata, line);
      step();
      chk_b("t3_gap_busy", busy, 1'b0);
    end
    ic_req = 1'b0; dc_req = 1'b0;
    step();

    // Late instruction contender during a data read
    dc_req = 1'b1; dc_addr = 32'h4000; mem_rdata = {4{32'hDDDD0001}};
    repeat (3) step();
    ic_req = 1'b1; ic_addr = 32'h500;
    run_until_ready(side, steps, en, we);
    chk_i("t4_first", side, 1);
    dc_req = 1'b0; mem_rdata = {4{32'h1C1C0002}};
    run_until_ready(side, steps, en, we);
    chk_i("t4_second", side, 0);
    chk_i("t4_steps", steps, 12);
    chk_i("t4_en_cycles", en, 10);
    chk_v("t4_ic_rdata", ic_rdata, {4{32'h1C1C0002}});
    chk_v("t4_mem_addr", LW'(mem_addr), LW'(32'h500));
    ic_req = 1'b0;
    step();

    // Reset in the fifth BUSY cycle, request held, then full-latency retry
    ic_req = 1'b1; ic_addr = 32'h600; mem_rdata = {4{32'h600D600D}};
    repeat (5) step();
    chk_b("t5_busy_before", mem_en, 1'b1);
    reset = 1'b0;
    #1;
    chk_b("t5_busy_cleared", busy, 1'b0);
    chk_b("t5_en_cleared", mem_en, 1'b0);
    step();
    reset = 1'b1;
    run_until_ready(side, steps, en, we);
    chk_i("t5_side", side, 0);
    chk_i("t5_steps", steps, 11);
    chk_v("t5_ic_rdata", ic_rdata, {4{32'h600D600D}});
    ic_req = 1'b0;
    step();

    // MEM_LAT=1 instance
    ic_req1 = 1'b1; ic_addr = 32'h900; mem_rdata = {4{32'h11110001}};
    steps = 0; en = 0; side = -1;
    for (int i = 0; i < 10 && side < 0; i++) begin
      step();
      steps++;
      if (mem_en1) en++;
      if (ic_ready1) side = 0;
    end
    chk_i("t6_side", side, 0);
    chk_i("t6_steps", steps, 2);
    chk_i("t6_en_cycles", en, 1);
    chk_v("t6_ic_rdata", ic_rdata1, {4{32'h11110001}});
    ic_req1 = 1'b0;
    step();
    chk_b("t6_idle_busy", busy1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
